// File: rtl/mem_port_arbiter.sv
// Purpose: shares one 32-bit memory port between instruction fetch and MEM-stage data, data-first with a fetch starvation guard.
// Latency: strobes appear 1 cycle after the grant edge; resp is combinational with mem_resp; one IDLE cycle between transactions.
// Backpressure: requesters hold their request until their resp pulse; the downstream port paces completion through mem_resp.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_read,
    input  logic [31:0] inst_address,
    output logic [31:0] inst_rdata,
    output logic        inst_resp,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_mbe,
    output logic [31:0] data_rdata,
    output logic        data_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        busy,
    output logic        proto_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  mbe_q;
    logic        wr_q;
    logic        data_req;
    logic        grant_i, grant_d;

    assign data_req = data_read | data_write;

    // Grant decision, starvation counter update and next state.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Fetch wins only when data is absent or fetch has waited out the limit.
                if (inst_read && (!data_req || starve_q == LIMIT)) begin
                    grant_i = 1'b1;
                end else if (data_req) begin
                    grant_d = 1'b1;
                end
                if (grant_i) begin
                    state_d = SERVE_I;
                end else if (grant_d) begin
                    state_d = SERVE_D;
                end
                if (!inst_read || grant_i) begin
                    starve_d = 4'd0;
                end else if (grant_d && starve_q != LIMIT) begin
                    starve_d = starve_q + 4'd1;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and starvation counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Capture the granted transaction so requester input changes cannot leak downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            mbe_q   <= 4'd0;
            wr_q    <= 1'b0;
        end else if (grant_i) begin
            addr_q  <= inst_address;
            wdata_q <= 32'd0;
            mbe_q   <= 4'b1111;
            wr_q    <= 1'b0;
        end else if (grant_d) begin
            addr_q  <= data_address;
            wdata_q <= data_wdata;
            mbe_q   <= data_mbe;
            wr_q    <= data_write;
        end
    end

    // Sticky flag for a data grant that carried both read and write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (grant_d && data_read && data_write) begin
            proto_err <= 1'b1;
        end
    end

    assign busy            = (state_q != IDLE);
    assign mem_read        = busy & ~wr_q;
    assign mem_write       = busy & wr_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;
    assign mem_byte_enable = mbe_q;

    assign inst_resp  = (state_q == SERVE_I) & mem_resp;
    assign data_resp  = (state_q == SERVE_D) & mem_resp;
    assign inst_rdata = inst_resp ? mem_rdata : 32'd0;
    assign data_rdata = data_resp ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_read;
    logic [31:0] inst_address;
    logic [31:0] inst_rdata;
    logic        inst_resp;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_wdata;
    logic [3:0]  data_mbe;
    logic [31:0] data_rdata;
    logic        data_resp;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        busy;
    logic        proto_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_read       (inst_read),
        .inst_address    (inst_address),
        .inst_rdata      (inst_rdata),
        .inst_resp       (inst_resp),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_address    (data_address),
        .data_wdata      (data_wdata),
        .data_mbe        (data_mbe),
        .data_rdata      (data_rdata),
        .data_resp       (data_resp),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .busy            (busy),
        .proto_err       (proto_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_read    = 1'b0;
        inst_address = 32'd0;
        data_read    = 1'b0;
        data_write   = 1'b0;
        data_address = 32'd0;
        data_wdata   = 32'd0;
        data_mbe     = 4'd0;
        mem_rdata    = 32'd0;
        mem_resp     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #12;
        tests++;
        if ({mem_read, mem_write, busy, proto_err, inst_resp, data_resp} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags got=%b want=000000",
                     {mem_read, mem_write, busy, proto_err, inst_resp, data_resp});
        end
        tests++;
        if ({mem_address, mem_wdata, mem_byte_enable, inst_rdata, data_rdata} !== 132'd0) begin
            fails++;
            $display("FAIL reset_buses addr=%h wdata=%h mbe=%h irdata=%h drdata=%h want all 0",
                     mem_address, mem_wdata, mem_byte_enable, inst_rdata, data_rdata);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        do_reset();
        inst_read    = 1'b1;
        inst_address = 32'h60;
        #1;
        tests++;
        if (mem_read !== 1'b0) begin
            fails++;
            $display("FAIL fetch_pre_grant mem_read got=%b want=0", mem_read);
        end
        tick();
        tests++;
        if ({mem_read, mem_write, mem_address, mem_byte_enable, busy} !== {1'b1, 1'b0, 32'h60, 4'hF, 1'b1}) begin
            fails++;
            $display("FAIL fetch_strobe rd=%b wr=%b addr=%h mbe=%h busy=%b want 1 0 00000060 f 1",
                     mem_read, mem_write, mem_address, mem_byte_enable, busy);
        end
        mem_resp  = 1'b1;
        mem_rdata = 32'h0000_0013;
        #1;
        tests++;
        if ({inst_resp, inst_rdata, data_resp} !== {1'b1, 32'h13, 1'b0}) begin
            fails++;
            $display("FAIL fetch_resp iresp=%b irdata=%h dresp=%b want 1 00000013 0",
                     inst_resp, inst_rdata, data_resp);
        end
        tick();
        mem_resp  = 1'b0;
        inst_read = 1'b0;
        #1;
        tests++;
        if ({mem_read, busy, inst_resp, inst_rdata} !== 35'd0) begin
            fails++;
            $display("FAIL fetch_idle rd=%b busy=%b iresp=%b irdata=%h want all 0",
                     mem_read, busy, inst_resp, inst_rdata);
        end
    endtask

    task automatic test_store();
        do_reset();
        data_write   = 1'b1;
        data_address = 32'h104;
        data_wdata   = 32'h0000_AB00;
        data_mbe     = 4'b0010;
        tick();
        tests++;
        if ({mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable}
                !== {1'b0, 1'b1, 32'h104, 32'h0000_AB00, 4'b0010}) begin
            fails++;
            $display("FAIL store_strobe rd=%b wr=%b addr=%h wdata=%h mbe=%b want 0 1 00000104 0000ab00 0010",
                     mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable);
        end
        mem_resp  = 1'b1;
        mem_rdata = 32'hDEAD_0001;
        #1;
        tests++;
        if ({data_resp, data_rdata, inst_resp, inst_rdata} !== {1'b1, 32'hDEAD_0001, 1'b0, 32'd0}) begin
            fails++;
            $display("FAIL store_resp dresp=%b drdata=%h iresp=%b irdata=%h want 1 dead0001 0 0",
                     data_resp, data_rdata, inst_resp, inst_rdata);
        end
        tick();
        mem_resp   = 1'b0;
        data_write = 1'b0;
    endtask

    task automatic test_contention();
        logic [9:0] seq;
        int         n;
        int         cyc;
        do_reset();
        inst_read    = 1'b1;
        inst_address = 32'h1000;
        data_read    = 1'b1;
        data_address = 32'h2000;
        seq = '0;
        n   = 0;
        cyc = 0;
        while (n < 10 && cyc < 200) begin
            tick();
            cyc++;
            mem_resp  = busy;
            mem_rdata = $urandom;
            #1;
            if (inst_resp || data_resp) begin
                seq = {seq[8:0], inst_resp};
                n++;
            end
        end
        mem_resp  = 1'b0;
        inst_read = 1'b0;
        data_read = 1'b0;
        tests++;
        if (n != 10) begin
            fails++;
            $display("FAIL contention_budget grants=%0d want=10", n);
        end
        tests++;
        if (seq !== 10'b0000100001) begin
            fails++;
            $display("FAIL contention_order got=%b want=0000100001 (1=inst, first grant at left)", seq);
        end
        tick();
        tick();
    endtask

    task automatic test_mid_change();
        do_reset();
        data_read    = 1'b1;
        data_address = 32'h200;
        tick();
        data_address = 32'h300;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if ({mem_read, mem_address} !== {1'b1, 32'h200}) begin
                fails++;
                $display("FAIL mid_change cycle%0d rd=%b addr=%h want 1 00000200", i, mem_read, mem_address);
            end
            tick();
        end
        data_read = 1'b0;
        mem_resp  = 1'b1;
        #1;
        tests++;
        if (data_resp !== 1'b1) begin
            fails++;
            $display("FAIL mid_change_drop_resp dresp=%b want 1", data_resp);
        end
        tick();
        mem_resp = 1'b0;
    endtask

    task automatic test_proto_err();
        do_reset();
        data_read    = 1'b1;
        data_write   = 1'b1;
        data_address = 32'h40;
        tick();
        tests++;
        if ({mem_read, mem_write, proto_err} !== 3'b011) begin
            fails++;
            $display("FAIL proto_write rd=%b wr=%b perr=%b want 0 1 1", mem_read, mem_write, proto_err);
        end
        mem_resp = 1'b1;
        tick();
        mem_resp   = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        tests++;
        if ({proto_err, busy} !== 2'b10) begin
            fails++;
            $display("FAIL proto_sticky perr=%b busy=%b want 1 0", proto_err, busy);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        inst_read    = 1'b1;
        inst_address = 32'h80;
        tick();
        tests++;
        if ({mem_read, busy} !== 2'b11) begin
            fails++;
            $display("FAIL areset_pre rd=%b busy=%b want 1 1", mem_read, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({mem_read, mem_write, busy} !== 3'b000) begin
            fails++;
            $display("FAIL areset_drop rd=%b wr=%b busy=%b want 0 0 0", mem_read, mem_write, busy);
        end
        inst_read = 1'b0;
        #3;
        rst = 1'b0;
        tick();
        tick();
        mem_resp  = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        tests++;
        if ({inst_resp, data_resp, busy, inst_rdata, data_rdata} !== 67'd0) begin
            fails++;
            $display("FAIL areset_stray iresp=%b dresp=%b busy=%b irdata=%h drdata=%h want all 0",
                     inst_resp, data_resp, busy, inst_rdata, data_rdata);
        end
        tick();
        mem_resp = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL areset_stay_idle busy=%b want 0", busy);
        end
    endtask

    // Transaction-level reference: who owns the port, what was captured, how long fetch has waited.
    task automatic test_random();
        int          owner;      // 0 none, 1 fetch, 2 data
        logic [31:0] t_addr, t_wdata;
        logic [3:0]  t_mbe;
        logic        t_wr;
        int          waits;
        bit          i_done, d_done;
        bit          e_ir, e_dr;
        int          n_i, n_d;
        int          bad;
        do_reset();
        owner = 0; t_addr = 0; t_wdata = 0; t_mbe = 0; t_wr = 0; waits = 0;
        i_done = 0; d_done = 0; n_i = 0; n_d = 0; bad = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (i_done) begin inst_read = 1'b0; i_done = 0; end
            if (d_done) begin data_read = 1'b0; data_write = 1'b0; d_done = 0; end
            if (!inst_read && ($urandom % 2 == 0)) begin
                inst_read    = 1'b1;
                inst_address = $urandom & 32'hFFFF_FFFC;
            end
            if (!(data_read || data_write) && ($urandom % 2 == 0)) begin
                data_write   = $urandom % 2;
                data_read    = ~data_write;
                data_address = $urandom & 32'hFFFF_FFFC;
                data_wdata   = $urandom;
                data_mbe     = 4'($urandom);
            end else if (owner == 2 && ($urandom % 4 == 0)) begin
                data_address = $urandom;
                data_wdata   = $urandom;
            end
            mem_resp  = ($urandom % 3 == 0);
            mem_rdata = $urandom;
            #1;
            e_ir = (owner == 1) && mem_resp;
            e_dr = (owner == 2) && mem_resp;
            tests++;
            if ({mem_read, mem_write, busy, proto_err} !== {owner != 0 && !t_wr, owner != 0 && t_wr, owner != 0, 1'b0}) begin
                fails++; bad++;
                if (bad < 10) $display("FAIL rand_strobes cyc=%0d rd/wr/busy/perr=%b%b%b%b owner=%0d wr=%b",
                                       c, mem_read, mem_write, busy, proto_err, owner, t_wr);
            end
            tests++;
            if ({mem_address, mem_wdata, mem_byte_enable} !== {t_addr, t_wdata, t_mbe}) begin
                fails++; bad++;
                if (bad < 10) $display("FAIL rand_bus cyc=%0d got=%h/%h/%h want=%h/%h/%h",
                                       c, mem_address, mem_wdata, mem_byte_enable, t_addr, t_wdata, t_mbe);
            end
            tests++;
            if ({inst_resp, inst_rdata, data_resp, data_rdata}
                    !== {e_ir, e_ir ? mem_rdata : 32'd0, e_dr, e_dr ? mem_rdata : 32'd0}) begin
                fails++; bad++;
                if (bad < 10) $display("FAIL rand_resp cyc=%0d iresp=%b irdata=%h dresp=%b drdata=%h want %b %b",
                                       c, inst_resp, inst_rdata, data_resp, data_rdata, e_ir, e_dr);
            end
            if (e_ir) begin i_done = 1; n_i++; end
            if (e_dr) begin d_done = 1; n_d++; end
            // Advance the reference across the coming clock edge.
            if (owner != 0) begin
                if (mem_resp) owner = 0;
            end else begin
                int grant;
                grant = 0;
                if (inst_read && (data_read || data_write) && waits >= LIMIT) grant = 1;
                else if (data_read || data_write) grant = 2;
                else if (inst_read) grant = 1;
                if (grant == 1) begin
                    t_addr = inst_address; t_wdata = 0; t_mbe = 4'hF; t_wr = 0;
                end else if (grant == 2) begin
                    t_addr = data_address; t_wdata = data_wdata; t_mbe = data_mbe; t_wr = data_write;
                end
                owner = grant;
                if (!inst_read || grant == 1) waits = 0;
                else if (grant == 2) waits = (waits + 1 > LIMIT) ? LIMIT : waits + 1;
            end
        end
        tests++;
        if (n_i < 20 || n_d < 20) begin
            fails++;
            $display("FAIL rand_progress inst_done=%0d data_done=%0d want >=20 each", n_i, n_d);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_mid_change();
        test_proto_err();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
